mult16_mac_accum: RTL and testbench

//   Sequential consumer stage for the mult16 multiplier. Registers operand pairs, feeds them to an

---
 rtl/mult16_mac_accum_if.sv | 29 ++
 rtl/mult16_mac_accum.sv | 174 +++++++++++++++++
 tb/tb_mult16_mac_accum.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult16_mac_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : mult16_mac_accum_if
// Brief    : Operand/result handshake bundle for the mult16 MAC accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface mult16_mac_accum_if #(
  parameter int ACC_WIDTH = 40
);
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          a;
  logic [15:0]          b;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 out_ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, acc_out, out_ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, acc_out, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/mult16_mac_accum.sv
`default_nettype none
// ============================================================================
// Module   : mult16_mac_accum
// Brief    : Registered operand stage feeding mult16, accumulating BLOCK_LEN
//            unsigned products per result. Define MULT16_MAC_SATURATE_EN to
//            clamp the accumulator on overflow instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================

module mult16 (
  input  wire logic [15:0] a,
  input  wire logic [15:0] b,
  output logic      [31:0] r
);
  assign r = 32'(a) * 32'(b);
endmodule

module mult16_mac_accum #(
  parameter int ACC_WIDTH = 40,
  parameter int BLOCK_LEN = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mult16_mac_accum_if.slave  bus
);

  localparam int                CNT_W    = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BLOCK_LEN - 1);

  typedef enum logic [0:0] {
    S_ACC  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          a_q, a_d;
  logic [15:0]          b_q, b_d;
  logic                 op_vld_q, op_vld_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
  logic                 out_ovf_q, out_ovf_d;

  logic [31:0]          prod;
  logic [ACC_WIDTH:0]   sum;
  logic                 block_ovf;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 is_last;
  logic                 out_free;
  logic                 consume;
  logic                 in_ready;
  logic                 accept;

  mult16 u_mult (
    .a (a_q),
    .b (b_q),
    .r (prod)
  );

  // Accumulator datapath: one extra bit catches the carry out of ACC_WIDTH.
  always_comb begin
    sum       = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - 32){1'b0}}, prod};
    block_ovf = ovf_q | sum[ACC_WIDTH];
`ifdef MULT16_MAC_SATURATE_EN
    acc_next  = block_ovf ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    acc_next  = sum[ACC_WIDTH-1:0];
`endif
  end

  // Control: the last product of a block may only retire into a free output register.
  always_comb begin
    state_d  = state_q;
    consume  = 1'b0;
    is_last  = (cnt_q == LAST_CNT);
    out_free = !out_valid_q || bus.out_ready;
    case (state_q)
      S_ACC: begin
        if (op_vld_q) begin
          if (!is_last || out_free) begin
            consume = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.out_ready) begin
          consume = 1'b1;
          state_d = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
    in_ready = !op_vld_q || consume;
    accept   = bus.in_valid && in_ready;
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    op_vld_d    = op_vld_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    acc_out_d   = acc_out_q;
    out_ovf_d   = out_ovf_q;

    if (accept) begin
      a_d      = bus.a;
      b_d      = bus.b;
      op_vld_d = 1'b1;
    end else if (consume) begin
      op_vld_d = 1'b0;
    end

    if (consume) begin
      if (is_last) begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = acc_next;
        cnt_d = cnt_q + CNT_W'(1);
        ovf_d = block_ovf;
      end
    end

    // A result loading in the same cycle as a handshake keeps out_valid high.
    if (consume && is_last) begin
      out_valid_d = 1'b1;
      acc_out_d   = acc_next;
      out_ovf_d   = block_ovf;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ACC;
      a_q         <= '0;
      b_q         <= '0;
      op_vld_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      acc_out_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_vld_q    <= op_vld_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      acc_out_q   <= acc_out_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mult16_mac_accum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mult16_mac_accum
// Brief    : Self-checking bench for mult16_mac_accum (block-of-4 and default
//            configurations) against a transaction-level sum-of-products model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult16_mac_accum;

  localparam int W4 = 33, BL4 = 4, W16 = 40, BL16 = 16;
`ifdef MULT16_MAC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #2 clk = ~clk;

  mult16_mac_accum_if #(.ACC_WIDTH(W4))  if4 ();
  mult16_mac_accum_if #(.ACC_WIDTH(W16)) if16 ();

  mult16_mac_accum #(.ACC_WIDTH(W4), .BLOCK_LEN(BL4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  mult16_mac_accum #(.ACC_WIDTH(W16), .BLOCK_LEN(BL16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.slave)
  );

  int total = 0;
  int bad   = 0;
  int nstep = 0;

  // Reference model: running sum of accepted products, one expected word {ovf, value} per block.
  longint unsigned m4_sum = 0, m16_sum = 0;
  int              m4_cnt = 0, m16_cnt = 0;
  logic [W4:0]     exp4[$], obs4[$];
  logic [W16:0]    exp16[$], obs16[$];
  int              res_step4[$];

  function automatic logic [W4:0] exp4_word(input longint unsigned s);
    logic          o;
    logic [W4-1:0] v;
    o = (s >> W4) != 0;
    v = (o && SAT) ? {W4{1'b1}} : W4'(s);
    return {o, v};
  endfunction

  function automatic logic [W16:0] exp16_word(input longint unsigned s);
    logic           o;
    logic [W16-1:0] v;
    o = (s >> W16) != 0;
    v = (o && SAT) ? {W16{1'b1}} : W16'(s);
    return {o, v};
  endfunction

  task automatic step4(input bit iv, input logic [15:0] av, input logic [15:0] bv,
                       input bit ordy, output bit acc, output bit ov, output logic [W4:0] val);
    @(negedge clk);
    if4.in_valid  = iv;
    if4.a         = av;
    if4.b         = bv;
    if4.out_ready = ordy;
    #1;
    nstep++;
    acc = iv && if4.in_ready;
    ov  = if4.out_valid;
    val = {if4.out_ovf, if4.acc_out};
    if (ov && ordy) begin
      obs4.push_back(val);
      res_step4.push_back(nstep);
    end
    if (acc) begin
      m4_sum += 64'(av) * 64'(bv);
      m4_cnt++;
      if (m4_cnt == BL4) begin
        exp4.push_back(exp4_word(m4_sum));
        m4_sum = 0;
        m4_cnt = 0;
      end
    end
  endtask

  task automatic step16(input bit iv, input logic [15:0] av, input logic [15:0] bv,
                        input bit ordy, output bit acc, output bit ov, output logic [W16:0] val);
    @(negedge clk);
    if16.in_valid  = iv;
    if16.a         = av;
    if16.b         = bv;
    if16.out_ready = ordy;
    #1;
    acc = iv && if16.in_ready;
    ov  = if16.out_valid;
    val = {if16.out_ovf, if16.acc_out};
    if (ov && ordy) obs16.push_back(val);
    if (acc) begin
      m16_sum += 64'(av) * 64'(bv);
      m16_cnt++;
      if (m16_cnt == BL16) begin
        exp16.push_back(exp16_word(m16_sum));
        m16_sum = 0;
        m16_cnt = 0;
      end
    end
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    rst            = 1'b1;
    if4.in_valid   = 1'b0;
    if16.in_valid  = 1'b0;
    if4.out_ready  = 1'b0;
    if16.out_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    rst     = 1'b0;
    m4_sum  = 0;
    m4_cnt  = 0;
    m16_sum = 0;
    m16_cnt = 0;
  endtask

  task automatic clear_queues();
    exp4.delete();
    obs4.delete();
    res_step4.delete();
    exp16.delete();
    obs16.delete();
  endtask

  task automatic test_reset();
    pulse_reset(2);
    #1;
    total += 8;
    if (if4.in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready4 got=%b want=1", if4.in_ready); end
    if (if4.out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid4 got=%b want=0", if4.out_valid); end
    if (if4.acc_out !== '0)      begin bad++; $display("FAIL reset_acc_out4 got=%h want=0", if4.acc_out); end
    if (if4.out_ovf !== 1'b0)    begin bad++; $display("FAIL reset_ovf4 got=%b want=0", if4.out_ovf); end
    if (if16.in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready16 got=%b want=1", if16.in_ready); end
    if (if16.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid16 got=%b want=0", if16.out_valid); end
    if (if16.acc_out !== '0)     begin bad++; $display("FAIL reset_acc_out16 got=%h want=0", if16.acc_out); end
    if (if16.out_ovf !== 1'b0)   begin bad++; $display("FAIL reset_ovf16 got=%b want=0", if16.out_ovf); end
  endtask

  task automatic test_basic();
    bit acc, ov;
    logic [W4:0] val;
    bit ovh[1:4];
    int nacc = 0;
    clear_queues();
    for (int i = 1; i <= 4; i++) begin
      step4(1'b1, 16'(i), 16'(i), 1'b1, acc, ov, val);
      if (acc) nacc++;
    end
    for (int j = 1; j <= 4; j++) begin
      step4(1'b0, 16'h0, 16'h0, 1'b1, acc, ov, val);
      ovh[j] = ov;
    end
    total += 4;
    if (nacc != 4) begin bad++; $display("FAIL basic_accepts got=%0d want=4", nacc); end
    if (ovh[1] !== 1'b0 || ovh[2] !== 1'b1 || ovh[3] !== 1'b0)
      begin bad++; $display("FAIL basic_latency got=%b%b%b want=010", ovh[1], ovh[2], ovh[3]); end
    if (obs4.size() != 1) begin bad++; $display("FAIL basic_count got=%0d want=1", obs4.size()); end
    else if (obs4[0] !== {1'b0, 33'd30}) begin bad++; $display("FAIL basic_value got=%h want=%h", obs4[0], {1'b0, 33'd30}); end
    if (obs4.size() == 1 && exp4.size() == 1 && obs4[0] !== exp4[0])
      begin bad++; $display("FAIL basic_model got=%h want=%h", obs4[0], exp4[0]); end
  endtask

  task automatic test_stream();
    bit acc, ov;
    logic [W4:0] val;
    int drops = 0;
    clear_queues();
    for (int i = 0; i < 16; i++) begin
      step4(1'b1, 16'd2, 16'd2, 1'b1, acc, ov, val);
      if (!acc) drops++;
    end
    for (int i = 0; i < 4; i++) step4(1'b0, 16'h0, 16'h0, 1'b1, acc, ov, val);
    total += 2;
    if (drops != 0) begin bad++; $display("FAIL stream_in_ready got=%0d drops want=0", drops); end
    if (obs4.size() != 4) begin bad++; $display("FAIL stream_count got=%0d want=4", obs4.size()); end
    for (int i = 0; i < obs4.size(); i++) begin
      total++;
      if (obs4[i] !== {1'b0, 33'd16}) begin bad++; $display("FAIL stream_value[%0d] got=%h want=%h", i, obs4[i], {1'b0, 33'd16}); end
      if (i > 0) begin
        total++;
        if (res_step4[i] - res_step4[i-1] != 4)
          begin bad++; $display("FAIL stream_spacing[%0d] got=%0d want=4", i, res_step4[i] - res_step4[i-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit acc, ov;
    logic [W4:0] val;
    int sent = 0;
    clear_queues();
    for (int i = 0; i < 24; i++) begin
      step4(sent < 8, 16'd1, 16'd1, 1'b0, acc, ov, val);
      if (acc) sent++;
    end
    total += 5;
    if (sent != 8) begin bad++; $display("FAIL bp_sent got=%0d want=8", sent); end
    if (if4.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", if4.in_ready); end
    if (if4.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b want=1", if4.out_valid); end
    if (val !== {1'b0, 33'd4}) begin bad++; $display("FAIL bp_hold_value got=%h want=%h", val, {1'b0, 33'd4}); end
    if (obs4.size() != 0) begin bad++; $display("FAIL bp_early_results got=%0d want=0", obs4.size()); end
    for (int i = 0; i < 8; i++) step4(1'b0, 16'h0, 16'h0, 1'b1, acc, ov, val);
    total++;
    if (obs4.size() != 2) begin bad++; $display("FAIL bp_count got=%0d want=2", obs4.size()); end
    for (int i = 0; i < obs4.size(); i++) begin
      total++;
      if (obs4[i] !== {1'b0, 33'd4}) begin bad++; $display("FAIL bp_value[%0d] got=%h want=%h", i, obs4[i], {1'b0, 33'd4}); end
    end
  endtask

  task automatic test_overflow();
    bit acc, ov;
    logic [W4:0] val;
    logic [W4:0] want;
    clear_queues();
    want = SAT ? {1'b1, 33'h1FFFFFFFF} : {1'b1, 33'h1FFF80004};
    for (int i = 0; i < 4; i++) step4(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, acc, ov, val);
    for (int i = 0; i < 4; i++) step4(1'b0, 16'h0, 16'h0, 1'b1, acc, ov, val);
    total++;
    if (obs4.size() != 1) begin bad++; $display("FAIL ovf_count got=%0d want=1", obs4.size()); end
    else begin
      total += 2;
      if (obs4[0] !== want) begin bad++; $display("FAIL ovf_value got=%h want=%h", obs4[0], want); end
      if (exp4.size() != 1 || obs4[0] !== exp4[0]) begin bad++; $display("FAIL ovf_model got=%h want=%h", obs4[0], exp4[0]); end
    end
  endtask

  task automatic test_reset_mid();
    bit acc, ov;
    logic [W4:0] val;
    clear_queues();
    for (int i = 0; i < 2; i++) step4(1'b1, 16'd9, 16'd9, 1'b1, acc, ov, val);
    pulse_reset(1);
    for (int i = 0; i < 4; i++) step4(1'b1, 16'd1, 16'd1, 1'b1, acc, ov, val);
    for (int i = 0; i < 4; i++) step4(1'b0, 16'h0, 16'h0, 1'b1, acc, ov, val);
    total++;
    if (obs4.size() != 1) begin bad++; $display("FAIL rstmid_count got=%0d want=1", obs4.size()); end
    else begin
      total++;
      if (obs4[0] !== {1'b0, 33'd4}) begin bad++; $display("FAIL rstmid_value got=%h want=%h", obs4[0], {1'b0, 33'd4}); end
    end
  endtask

  task automatic test_random();
    bit acc, ov, iv, ordy;
    logic [W16:0] val, hold_val;
    logic [15:0] av, bv;
    bit hold = 1'b0;
    int sent = 0;
    int steps = 0;
    clear_queues();
    while (sent < 1000 && steps < 8000) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      av   = 16'($urandom);
      bv   = 16'($urandom);
      step16(iv, av, bv, ordy, acc, ov, val);
      steps++;
      if (acc) sent++;
      if (hold) begin
        total++;
        if (!ov || val !== hold_val) begin bad++; $display("FAIL rand_hold got=%b/%h want=1/%h", ov, val, hold_val); end
      end
      hold     = ov && !ordy;
      hold_val = val;
    end
    for (int i = 0; i < 40; i++) step16(1'b0, 16'h0, 16'h0, 1'b1, acc, ov, val);
    total += 2;
    if (sent != 1000) begin bad++; $display("FAIL rand_sent got=%0d want=1000", sent); end
    if (obs16.size() != exp16.size() || exp16.size() != 62)
      begin bad++; $display("FAIL rand_count got=%0d want=%0d (62)", obs16.size(), exp16.size()); end
    for (int i = 0; i < obs16.size() && i < exp16.size(); i++) begin
      total++;
      if (obs16[i] !== exp16[i]) begin bad++; $display("FAIL rand_value[%0d] got=%h want=%h", i, obs16[i], exp16[i]); end
    end
  endtask

  initial begin
    if4.in_valid   = 1'b0;
    if4.a          = '0;
    if4.b          = '0;
    if4.out_ready  = 1'b0;
    if16.in_valid  = 1'b0;
    if16.a         = '0;
    if16.b         = '0;
    if16.out_ready = 1'b0;
    void'($urandom(0));
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
